// File: rtl/sccb_pkg.sv
// Shared constants and state type for the SCCB camera init sequencer.
// Table entries are {reg, val}; two reserved codes act as control markers.
package sccb_pkg;

    localparam logic [15:0] SCCB_END   = 16'hFFFF;
    localparam logic [15:0] SCCB_DELAY = 16'hFFF0;

    localparam int unsigned PROFILE_QVGA_MIN  = 0;
    localparam int unsigned PROFILE_FULL_TUNE = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_DONE,
        DELAY,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/sccb_cfg_rom.sv
// Camera init tables, one per profile, with a registered output.
// Any address past a table's end marker, or an unknown profile, reads as SCCB_END.
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned NUM_PROFILES = 2,
    localparam int unsigned PROF_W      = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
    input  logic              clk,
    input  logic [PROF_W-1:0] profile,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout
);

    logic [31:0] w_idx;
    logic [31:0] w_prof;
    logic [15:0] w_entry;

    assign w_idx  = 32'(addr);
    assign w_prof = 32'(profile);

    always_comb begin
        w_entry = SCCB_END;
        if (w_prof == PROFILE_QVGA_MIN) begin
            case (w_idx)
                0:       w_entry = 16'h1280;
                1:       w_entry = 16'h1214;
                2:       w_entry = 16'h40D0;
                3:       w_entry = 16'h13E7;
                4:       w_entry = 16'h5578;
                default: w_entry = SCCB_END;
            endcase
        end else if (w_prof == PROFILE_FULL_TUNE) begin
            // Soft reset must settle before any further register write lands.
            case (w_idx)
                0:       w_entry = 16'h1280;
                1:       w_entry = SCCB_DELAY;
                2:       w_entry = 16'h1214;
                3:       w_entry = 16'h1716;
                4:       w_entry = 16'h1804;
                5:       w_entry = 16'h3224;
                6:       w_entry = 16'h1902;
                7:       w_entry = 16'h1A7A;
                8:       w_entry = 16'h030A;
                9:       w_entry = 16'h4F80;
                10:      w_entry = 16'h5080;
                11:      w_entry = 16'h5100;
                12:      w_entry = 16'h5222;
                13:      w_entry = 16'h535E;
                14:      w_entry = 16'h5480;
                15:      w_entry = 16'h589E;
                16:      w_entry = 16'h7A20;
                17:      w_entry = 16'h7B10;
                18:      w_entry = 16'h7C1E;
                19:      w_entry = 16'h7D35;
                20:      w_entry = 16'h13E7;
                21:      w_entry = 16'h0000;
                22:      w_entry = 16'h1418;
                23:      w_entry = 16'h2495;
                24:      w_entry = 16'h2533;
                25:      w_entry = 16'h26E3;
                26:      w_entry = 16'h40D0;
                default: w_entry = SCCB_END;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        dout <= w_entry;
    end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the selected init table and issues {reg,val} writes to the SCCB master,
// handling delay/end markers, NACK retry, abort and table overrun.
module sccb_init_sequencer
    import sccb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned NUM_PROFILES = 2,
    parameter int unsigned DELAY_CYCLES = 250000,
    parameter int unsigned MAX_RETRY    = 3,
    localparam int unsigned PROF_W      = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PROF_W-1:0] profile_sel,
    output logic              wr_req,
    output logic [7:0]        wr_reg,
    output logic [7:0]        wr_val,
    input  logic              wr_ack,
    input  logic              wr_done,
    input  logic              wr_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] cur_index
);

    localparam int unsigned DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_t        r_state,   w_state;
    logic [PROF_W-1:0] r_profile, w_profile;
    logic [ADDR_W-1:0] r_index,   w_index;
    logic [RTY_W-1:0]  r_retry,   w_retry;
    logic [DLY_W-1:0]  r_delay,   w_delay;
    logic [7:0]        r_wr_reg,  w_wr_reg;
    logic [7:0]        r_wr_val,  w_wr_val;
    logic              r_busy,    w_busy;
    logic              r_done,    w_done;
    logic              r_error,   w_error;
    logic              r_abort_pend, w_abort_pend;
    logic              w_wr_req;
    logic [15:0]       w_rom_dout;
    logic              w_last_index;

    sccb_cfg_rom #(
        .ADDR_W       (ADDR_W),
        .NUM_PROFILES (NUM_PROFILES)
    ) u_rom (
        .clk     (clk),
        .profile (r_profile),
        .addr    (r_index),
        .dout    (w_rom_dout)
    );

    assign w_last_index = (r_index == '1);

    always_comb begin
        w_state      = r_state;
        w_profile    = r_profile;
        w_index      = r_index;
        w_retry      = r_retry;
        w_delay      = r_delay;
        w_wr_reg     = r_wr_reg;
        w_wr_val     = r_wr_val;
        w_busy       = r_busy;
        w_done       = r_done;
        w_error      = r_error;
        w_abort_pend = r_abort_pend;
        w_wr_req     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_profile = profile_sel;
                    w_index   = '0;
                    w_retry   = '0;
                    w_done    = 1'b0;
                    w_error   = 1'b0;
                    w_busy    = 1'b1;
                    w_state   = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_state = DECODE;
                end
            end
            DECODE: begin
                if (abort) begin
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else if (w_rom_dout == SCCB_END) begin
                    w_state = FINISH;
                end else if (w_rom_dout == SCCB_DELAY) begin
                    w_delay = '0;
                    w_state = DELAY;
                end else begin
                    w_wr_reg = w_rom_dout[15:8];
                    w_wr_val = w_rom_dout[7:0];
                    w_state  = ISSUE;
                end
            end
            ISSUE: begin
                // Abort withdraws the request combinationally so no new transfer can start.
                if (abort) begin
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_wr_req = 1'b1;
                    if (wr_ack) begin
                        w_abort_pend = 1'b0;
                        w_state      = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // Abort is remembered so a short pulse still stops the run once the transfer ends.
                if (abort) begin
                    w_abort_pend = 1'b1;
                end
                if (wr_done) begin
                    w_abort_pend = 1'b0;
                    if (abort || r_abort_pend) begin
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end else if (!wr_nack) begin
                        w_retry = '0;
                        if (w_last_index) begin
                            w_error = 1'b1;
                            w_busy  = 1'b0;
                            w_state = IDLE;
                        end else begin
                            w_index = r_index + ADDR_W'(1);
                            w_state = FETCH;
                        end
                    end else if (r_retry < RTY_W'(MAX_RETRY)) begin
                        w_retry = r_retry + RTY_W'(1);
                        w_state = ISSUE;
                    end else begin
                        w_error = 1'b1;
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end
                end
            end
            DELAY: begin
                if (abort) begin
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else if (r_delay == DLY_W'(DELAY_CYCLES - 1)) begin
                    if (w_last_index) begin
                        w_error = 1'b1;
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end else begin
                        w_index = r_index + ADDR_W'(1);
                        w_state = FETCH;
                    end
                end else begin
                    w_delay = r_delay + DLY_W'(1);
                end
            end
            FINISH: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = IDLE;
            end
            default: begin
                w_busy  = 1'b0;
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_profile    <= '0;
            r_index      <= '0;
            r_retry      <= '0;
            r_delay      <= '0;
            r_wr_reg     <= '0;
            r_wr_val     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_profile    <= w_profile;
            r_index      <= w_index;
            r_retry      <= w_retry;
            r_delay      <= w_delay;
            r_wr_reg     <= w_wr_reg;
            r_wr_val     <= w_wr_val;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_error      <= w_error;
            r_abort_pend <= w_abort_pend;
        end
    end

    assign wr_req    = w_wr_req;
    assign wr_reg    = r_wr_reg;
    assign wr_val    = r_wr_val;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign cur_index = r_index;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench: a table-walking reference model queues expected writes,
// an SCCB master model responds, and a monitor checks every request it sees.
`timescale 1ns/1ps
module tb_sccb_init_sequencer;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned NUM_PROFILES = 2;
    localparam int unsigned DELAY_CYCLES = 20;
    localparam int unsigned MAX_RETRY    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [0:0]        profile_sel = 1'b0;
    logic              wr_req;
    logic [7:0]        wr_reg;
    logic [7:0]        wr_val;
    logic              wr_ack = 1'b0;
    logic              wr_done = 1'b0;
    logic              wr_nack = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] cur_index;

    always #5 clk = ~clk;

    sccb_init_sequencer #(
        .ADDR_W       (ADDR_W),
        .NUM_PROFILES (NUM_PROFILES),
        .DELAY_CYCLES (DELAY_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .profile_sel (profile_sel),
        .wr_req      (wr_req),
        .wr_reg      (wr_reg),
        .wr_val      (wr_val),
        .wr_ack      (wr_ack),
        .wr_done     (wr_done),
        .wr_nack     (wr_nack),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cur_index   (cur_index)
    );

    typedef struct {
        logic [7:0] r;
        logic [7:0] v;
        int         gap;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    bit      nack_q[$];
    int      n_checks = 0;
    int      n_fail = 0;
    int      hs_count = 0;
    int      ack_min = 0, ack_max = 0, done_min = 5, done_max = 5;

    logic [15:0] tbl0[$] = '{16'h1280, 16'h1214, 16'h40D0, 16'h13E7, 16'h5578};
    logic [15:0] tbl1[$] = '{16'h1280, 16'hFFF0, 16'h1214, 16'h1716, 16'h1804, 16'h3224,
                             16'h1902, 16'h1A7A, 16'h030A, 16'h4F80, 16'h5080, 16'h5100,
                             16'h5222, 16'h535E, 16'h5480, 16'h589E, 16'h7A20, 16'h7B10,
                             16'h7C1E, 16'h7D35, 16'h13E7, 16'h0000, 16'h1418, 16'h2495,
                             16'h2533, 16'h26E3, 16'h40D0};

    function automatic void check(string name, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [15:0] tbl_entry(int prof, int idx);
        if (prof == 0) return (idx < tbl0.size()) ? tbl0[idx] : 16'hFFFF;
        return (idx < tbl1.size()) ? tbl1[idx] : 16'hFFFF;
    endfunction

    // Reference: walk the table, expanding each write into its attempts and
    // predicting the cycle gap from the previous wr_done (or start) to wr_req.
    task automatic plan_run(input int prof, input bit rnd, input int tgt_w, input int tgt_n,
                            output bit e_done, output bit e_err, output int e_idx);
        int idx = 0;
        int gap = 3;
        int wcnt = 0;
        int n;
        int att;
        logic [15:0] e;
        e_done = 1'b0;
        e_err  = 1'b0;
        forever begin
            e = tbl_entry(prof, idx);
            if (e == 16'hFFFF) begin
                e_done = 1'b1;
                break;
            end
            if (e == 16'hFFF0) begin
                gap += int'(DELAY_CYCLES) + 2;
            end else begin
                if (wcnt == tgt_w) n = tgt_n;
                else if (rnd && $urandom_range(0, 7) == 0) n = int'($urandom_range(1, MAX_RETRY));
                else n = 0;
                att = (n > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : n + 1;
                for (int a = 0; a < att; a++) begin
                    exp_q.push_back('{e[15:8], e[7:0], (a == 0) ? gap : 1});
                    nack_q.push_back(a < n);
                end
                if (n > int'(MAX_RETRY)) begin
                    e_err = 1'b1;
                    break;
                end
                wcnt++;
                gap = 3;
            end
            if (idx == (2 ** ADDR_W) - 1) begin
                e_err = 1'b1;
                break;
            end
            idx++;
        end
        e_idx = idx;
    endtask

    // SCCB master model: acks after a random wait, finishes after a random latency.
    initial begin : master
        int  ack_wait;
        int  cnt;
        bit  xfer;
        bit  cur_nack;
        ack_wait = 0;
        cnt = 0;
        xfer = 1'b0;
        cur_nack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            wr_ack  = 1'b0;
            wr_done = 1'b0;
            wr_nack = 1'b0;
            if (!rst_n) begin
                xfer = 1'b0;
            end else if (xfer) begin
                if (cnt <= 1) begin
                    wr_done = 1'b1;
                    wr_nack = cur_nack;
                    xfer = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (wr_req) begin
                if (ack_wait == 0) begin
                    wr_ack = 1'b1;
                    xfer = 1'b1;
                    cnt = int'($urandom_range(done_min, done_max));
                    cur_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                end else begin
                    ack_wait--;
                end
            end else begin
                ack_wait = int'($urandom_range(ack_min, ack_max));
            end
        end
    end

    initial begin : monitor
        int      cyc;
        int      ref_cyc;
        bit      prev_req;
        wr_exp_t cur;
        cyc = 0;
        ref_cyc = 0;
        prev_req = 1'b0;
        cur = '{8'h00, 8'h00, 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (start && !abort && !busy) ref_cyc = cyc;
                if (wr_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got request %h/%h, expected none", wr_reg, wr_val);
                    end else begin
                        cur = exp_q.pop_front();
                        check("wr_reg", wr_reg, cur.r);
                        check("wr_val", wr_val, cur.v);
                        check("req_gap", cyc - ref_cyc, cur.gap);
                    end
                end
                if (wr_req && wr_ack) begin
                    hs_count++;
                    check("handshake_reg_val", {wr_reg, wr_val}, {cur.r, cur.v});
                end
                if (wr_done) ref_cyc = cyc;
                prev_req = wr_req;
            end
        end
    end

    task automatic start_seq(input int prof);
        @(posedge clk); #1;
        profile_sel = 1'(prof);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        profile_sel = ~profile_sel;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_idle_timeout"}, (t < 5000) ? 1 : 0, 1);
    endtask

    task automatic full_run(input string tag, input int prof, input bit rnd, input int tw, input int tn);
        bit ed;
        bit ee;
        int ei;
        plan_run(prof, rnd, tw, tn, ed, ee, ei);
        start_seq(prof);
        check({tag, "_busy"}, busy, 1);
        wait_idle(tag);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done"}, done, ed);
        check({tag, "_error"}, error, ee);
        check({tag, "_index"}, cur_index, ei);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        int t;
        #23;
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_reg", wr_reg, 0);
        check("rst_wr_val", wr_val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_index", cur_index, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        full_run("p0_ideal", 0, 1'b0, -1, 0);

        ack_min = 0; ack_max = 2;
        full_run("p1_delay", 1, 1'b0, -1, 0);

        full_run("nack2", 0, 1'b0, 1, 2);
        full_run("nack4", 0, 1'b0, 1, int'(MAX_RETRY) + 1);

        // Abort while write 3 is in flight.
        ack_min = 0; ack_max = 0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{tbl0[k][15:8], tbl0[k][7:0], 3});
            nack_q.push_back(1'b0);
        end
        base = hs_count;
        start_seq(0);
        t = 0;
        while (hs_count < base + 3 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_wd_reach", (t < 2000) ? 1 : 0, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        check("abort_wd_waits", busy, 1);
        wait_idle("abort_wd");
        abort = 1'b0;
        check("abort_wd_done", done, 0);
        check("abort_wd_error", error, 0);
        check("abort_wd_index", cur_index, 2);
        check("abort_wd_exp_left", exp_q.size(), 0);
        full_run("restart", 0, 1'b0, -1, 0);

        // Abort before the master acknowledges.
        ack_min = 4; ack_max = 4;
        start_seq(0);
        t = 0;
        while (!wr_req && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_iss_req_seen", wr_req, 1);
        abort = 1'b1;
        #1;
        check("abort_iss_req_drop", wr_req, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_iss_busy", busy, 0);
        check("abort_iss_done", done, 0);
        check("abort_iss_error", error, 0);
        nack_q.delete();

        // Simultaneous start and abort while idle.
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("start_abort_busy", busy, 0);
        check("start_abort_req", wr_req, 0);

        // Reset in the middle of the delay marker.
        ack_min = 0; ack_max = 0; done_min = 5; done_max = 5;
        begin
            bit ed;
            bit ee;
            int ei;
            plan_run(1, 1'b0, -1, 0, ed, ee, ei);
        end
        base = hs_count;
        start_seq(1);
        t = 0;
        while (hs_count < base + 1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_index", cur_index, 0);
        check("mid_rst_wr_req", wr_req, 0);
        check("mid_rst_wr_regval", {wr_reg, wr_val}, 0);
        exp_q.delete();
        nack_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        full_run("post_rst", 0, 1'b0, -1, 0);

        ack_min = 0; ack_max = 2; done_min = 1; done_max = 6;
        for (int r = 0; r < 6; r++) begin
            int prof;
            int tn;
            prof = int'($urandom_range(0, 1));
            tn = ($urandom_range(0, 3) == 0) ? int'(MAX_RETRY) + 1 : 0;
            full_run($sformatf("rand%0d", r), prof, 1'b1, int'($urandom_range(0, 4)), tn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
